// File: rtl/seg_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_if
// Brief    : BCD digit inputs, display controls and multiplexed display outputs
// Revision : 1.0
// ============================================================================
interface seg_scan_if;
    logic [3:0] sec1;
    logic [3:0] sec_10;
    logic [3:0] min1;
    logic [3:0] min_10;
    logic [3:0] hour1;
    logic [3:0] hour_10;
    logic [5:0] blink_mask;
    logic       lz_blank;
    logic [5:0] dig_sel;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    modport master (
        output sec1, sec_10, min1, min_10, hour1, hour_10, blink_mask, lz_blank,
        input  dig_sel, seg, dp, frame_tick
    );

    modport slave (
        input  sec1, sec_10, min1, min_10, hour1, hour_10, blink_mask, lz_blank,
        output dig_sel, seg, dp, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan
// Brief    : Six-digit multiplexed 7-segment scanner with frame-latched digits
// Revision : 1.0
// ============================================================================
module seg_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 100
) (
    input  logic         clk,
    input  logic         rst_n,
    seg_scan_if.slave    bus
);
    localparam int         PW     = $clog2(SCAN_DIV);
    localparam int         FW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_BLNK = PW'(BLANK_CYC);
    localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [2:0]    I_LAST = 3'd5;

    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic              blink_q, blink_d;
    logic [5:0][3:0]   shadow_q, shadow_d;
    logic [5:0]        dig_sel_q, dig_sel_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              tick_q, tick_d;
    logic              w_blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        pcnt_d   = pcnt_q + 1'b1;
        idx_d    = idx_q;
        fcnt_d   = fcnt_q;
        blink_d  = blink_q;
        shadow_d = shadow_q;
        tick_d   = 1'b0;

        if (pcnt_q == P_LAST) begin
            pcnt_d = '0;
            idx_d  = (idx_q == I_LAST) ? 3'd0 : idx_q + 3'd1;
            // Frame wrap: latch all digits at once so a frame never mixes old and new time
            if (idx_q == I_LAST) begin
                shadow_d = {bus.hour_10, bus.hour1, bus.min_10, bus.min1, bus.sec_10, bus.sec1};
                tick_d   = 1'b1;
                if (fcnt_q == F_LAST) begin
                    fcnt_d  = '0;
                    blink_d = ~blink_q;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
        end

        w_blank   = (bus.blink_mask[idx_q] & blink_q) |
                    ((idx_q == I_LAST) & bus.lz_blank & (shadow_q[5] == 4'd0));
        seg_d     = w_blank ? 7'b1111111 : decode(shadow_q[idx_q]);
        dp_d      = ~(((idx_q == 3'd2) || (idx_q == 3'd4)) && !blink_q);
        dig_sel_d = (pcnt_q < P_BLNK) ? 6'b111111 : ~(6'b000001 << idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q    <= '0;
            idx_q     <= '0;
            fcnt_q    <= '0;
            blink_q   <= 1'b0;
            shadow_q  <= '0;
            dig_sel_q <= 6'b111111;
            seg_q     <= 7'b1111111;
            dp_q      <= 1'b1;
            tick_q    <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            idx_q     <= idx_d;
            fcnt_q    <= fcnt_d;
            blink_q   <= blink_d;
            shadow_q  <= shadow_d;
            dig_sel_q <= dig_sel_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.dig_sel    = dig_sel_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = tick_q;
endmodule
`default_nettype wire

// File: tb/tb_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan
// Brief    : Self-checking bench for seg_scan against a cycle-count display model
// Revision : 1.0
// ============================================================================
module tb_seg_scan;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int BF = 2;
    localparam int FR = 6 * SD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_if bus ();

    seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         total  = 0;
    int         passed = 0;
    int         n      = 0;
    logic [3:0] sh [6];
    logic [6:0] tbl [10];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, n, obs, exp);
    endtask

    function automatic logic [3:0] in_digit(input int i);
        case (i)
            0:       in_digit = bus.sec1;
            1:       in_digit = bus.sec_10;
            2:       in_digit = bus.min1;
            3:       in_digit = bus.min_10;
            4:       in_digit = bus.hour1;
            default: in_digit = bus.hour_10;
        endcase
    endfunction

    // Expected outputs after each edge follow from the elapsed cycle count since reset.
    task automatic step();
        int k, pc, id, bl;
        logic [3:0] d;
        logic [5:0] e_dig;
        logic [6:0] e_seg;
        logic       e_dp, e_tick, blank;
        @(posedge clk);
        k  = n;
        pc = k % SD;
        id = (k / SD) % 6;
        bl = ((k / FR) / BF) % 2;
        d  = sh[id];
        blank  = (bus.blink_mask[id] && bl == 1) || (id == 5 && bus.lz_blank && sh[5] == 4'd0);
        e_seg  = (blank || d > 4'd9) ? 7'b1111111 : tbl[d];
        e_dig  = (pc < BC) ? 6'b111111 : ~(6'b000001 << id);
        e_dp   = !((id == 2 || id == 4) && bl == 0);
        e_tick = (k % FR == FR - 1);
        if (e_tick)
            for (int i = 0; i < 6; i++) sh[i] = in_digit(i);
        n++;
        @(negedge clk);
        check("dig_sel",    {2'b0, bus.dig_sel},    {2'b0, e_dig});
        check("seg",        {1'b0, bus.seg},        {1'b0, e_seg});
        check("dp",         {7'b0, bus.dp},         {7'b0, e_dp});
        check("frame_tick", {7'b0, bus.frame_tick}, {7'b0, e_tick});
    endtask

    task automatic run(input int c);
        for (int i = 0; i < c; i++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dig_sel"}, {2'b0, bus.dig_sel},    8'h3F);
        check({tag, "_seg"},     {1'b0, bus.seg},        8'h7F);
        check({tag, "_dp"},      {7'b0, bus.dp},         8'h01);
        check({tag, "_tick"},    {7'b0, bus.frame_tick}, 8'h00);
    endtask

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < 6; i++) sh[i] = 4'd0;
    endtask

    initial begin
        tbl[0] = 7'b1000000; tbl[1] = 7'b1111001; tbl[2] = 7'b0100100;
        tbl[3] = 7'b0110000; tbl[4] = 7'b0011001; tbl[5] = 7'b0010010;
        tbl[6] = 7'b0000010; tbl[7] = 7'b1111000; tbl[8] = 7'b0000000;
        tbl[9] = 7'b0010000;
        bus.hour_10 = 4'd1; bus.hour1 = 4'd2; bus.min_10 = 4'd3;
        bus.min1    = 4'd4; bus.sec_10 = 4'd5; bus.sec1  = 4'd6;
        bus.blink_mask = 6'b000000;
        bus.lz_blank   = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        run(3);
        check("c3_dig_sel", {2'b0, bus.dig_sel}, 8'h3E);
        check("c3_seg",     {1'b0, bus.seg},     8'h40);
        run(8);
        check("c11_dig_sel", {2'b0, bus.dig_sel}, 8'h3D);
        run(8);
        check("slot2_dp", {7'b0, bus.dp}, 8'h00);
        run(29);
        check("first_tick", {7'b0, bus.frame_tick}, 8'h01);
        run(3);
        check("f1_slot0_seg", {1'b0, bus.seg}, 8'h02);
        run(40);
        check("f1_slot5_seg", {1'b0, bus.seg}, 8'h79);

        bus.min1 = 4'hB;
        run(24);
        check("hex_b_seg",     {1'b0, bus.seg},     8'h7F);
        check("hex_b_dig_sel", {2'b0, bus.dig_sel}, 8'h3B);

        bus.blink_mask = 6'b000011;
        run(80);
        check("blink_on_seg", {1'b0, bus.seg}, 8'h02);
        run(96);
        check("blink_off_seg", {1'b0, bus.seg}, 8'h7F);
        run(16);
        check("blink_off_dp", {7'b0, bus.dp}, 8'h01);

        bus.blink_mask = 6'b000000;
        bus.lz_blank   = 1'b1;
        bus.hour_10    = 4'd0;
        run(72);
        check("lz_slot5_seg", {1'b0, bus.seg}, 8'h7F);
        bus.hour_10 = 4'd2;
        run(48);
        check("lz_h10_2_seg", {1'b0, bus.seg}, 8'h24);

        for (int r = 0; r < 100; r++) begin
            bus.sec1    = 4'($urandom_range(0, 15));
            bus.sec_10  = 4'($urandom_range(0, 15));
            bus.min1    = 4'($urandom_range(0, 15));
            bus.min_10  = 4'($urandom_range(0, 15));
            bus.hour1   = 4'($urandom_range(0, 15));
            bus.hour_10 = 4'($urandom_range(0, 3));
            bus.blink_mask = 6'($urandom);
            bus.lz_blank   = 1'($urandom);
            run(int'($urandom_range(3, 13)));
        end

        while (n % FR != 3 * SD + 5) step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("held");
        bus.lz_blank = 1'b0;
        model_reset();
        rst_n = 1'b1;
        run(3);
        check("rst_c3_dig_sel", {2'b0, bus.dig_sel}, 8'h3E);
        run(60);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
